// File: rtl/dmem_pp_pkg.sv
// rtl/dmem_pp_pkg.sv - shared types and constants for the dmem ping-pong controller
package dmem_pp_pkg;

  typedef enum logic {
    WR_FILL = 1'b0,
    WR_FULL = 1'b1
  } wr_state_e;

  typedef enum logic {
    RD_EMPTY  = 1'b0,
    RD_ACTIVE = 1'b1
  } rd_state_e;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/dmem_skid_fifo.sv
// rtl/dmem_skid_fifo.sv - two-entry skid FIFO catching dmem read data
module dmem_skid_fifo
  import dmem_pp_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            push,
  input  logic [BITS-1:0] push_data,
  input  logic            pop,
  output logic [BITS-1:0] head,
  output logic [1:0]      cnt
);

  logic [BITS-1:0] mem [SKID_DEPTH];
  logic            wr_ptr;
  logic            rd_ptr;
  logic            pop_ok;
  logic            push_ok;

  // The reader's issue throttle keeps pushes within capacity; the guards only
  // protect pointer state if a caller ever breaks that contract.
  assign pop_ok  = pop && (cnt != 2'd0);
  assign push_ok = push && ((cnt != 2'(SKID_DEPTH)) || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (clr) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/dmem_pp_ctrl.sv
// rtl/dmem_pp_ctrl.sv - ping-pong bank controller driving the PE data memory pins
module dmem_pp_ctrl
  import dmem_pp_pkg::*;
#(
  parameter int BITS = 32,
  parameter int ADDR = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            flush,
  input  logic [ADDR-2:0] frame_len,
  input  logic            in_valid,
  input  logic [BITS-1:0] in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [BITS-1:0] out_data,
  input  logic            out_ready,
  output logic            cen,
  output logic            gwen,
  output logic [ADDR-1:0] addr_r,
  output logic [ADDR-1:0] addr_w,
  output logic [BITS-1:0] data_i,
  input  logic [BITS-1:0] data_o,
  output logic            bank_o,
  output logic            swap_o
);

  localparam int OFF = ADDR - 1;

  wr_state_e       wr_state_q, wr_state_d;
  rd_state_e       rd_state_q, rd_state_d;
  logic [OFF-1:0]  wr_off_q, wr_off_d, wr_len_q, wr_len_d;
  logic [OFF-1:0]  rd_off_q, rd_off_d, rd_len_q, rd_len_d;
  logic            rb_q, rb_d;
  logic            started_q;
  logic            wr_pend_q, inflight_q, swap_q;
  logic [BITS-1:0] data_i_q;
  logic [ADDR-1:0] addr_w_q;
  logic            accept, pop, rd_issue, swap;
  logic [2:0]      occ;
  logic [1:0]      fifo_cnt;
  logic [BITS-1:0] fifo_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= WR_FILL;
      rd_state_q <= RD_EMPTY;
      wr_off_q   <= '0;
      wr_len_q   <= '0;
      rd_off_q   <= '0;
      rd_len_q   <= '0;
      rb_q       <= 1'b0;
      started_q  <= 1'b0;
    end else if (flush) begin
      wr_state_q <= WR_FILL;
      rd_state_q <= RD_EMPTY;
      wr_off_q   <= '0;
      wr_len_q   <= '0;
      rd_off_q   <= '0;
      rd_len_q   <= '0;
      rb_q       <= 1'b0;
      started_q  <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wr_off_q   <= wr_off_d;
      wr_len_q   <= wr_len_d;
      rd_off_q   <= rd_off_d;
      rd_len_q   <= rd_len_d;
      rb_q       <= rb_d;
      started_q  <= 1'b1;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    rd_state_d = rd_state_q;
    wr_off_d   = wr_off_q;
    wr_len_d   = wr_len_q;
    rd_off_d   = rd_off_q;
    rd_len_d   = rd_len_q;
    rb_d       = rb_q;

    // started_q holds the writer out for one cycle so wr_len can latch frame_len.
    in_ready = en && started_q && (wr_state_q == WR_FILL);
    accept   = in_valid && in_ready;
    pop      = out_valid && out_ready;
    occ      = {1'b0, fifo_cnt} + {2'b0, inflight_q};
    rd_issue = (rd_state_q == RD_ACTIVE) && en && (occ < (3'd2 + {2'b0, pop}));
    swap     = (wr_state_q == WR_FULL) && (rd_state_q == RD_EMPTY) && !inflight_q && en;

    if (!started_q) wr_len_d = frame_len;

    if (accept) begin
      if (wr_off_q == wr_len_q) wr_state_d = WR_FULL;
      else                      wr_off_d   = wr_off_q + 1'b1;
    end

    if (rd_issue) begin
      if (rd_off_q == rd_len_q) rd_state_d = RD_EMPTY;
      else                      rd_off_d   = rd_off_q + 1'b1;
    end

    // Swap excludes accept and issue by state, so these overrides never collide.
    if (swap) begin
      rb_d       = ~rb_q;
      rd_len_d   = wr_len_q;
      wr_len_d   = frame_len;
      wr_off_d   = '0;
      rd_off_d   = '0;
      wr_state_d = WR_FILL;
      rd_state_d = RD_ACTIVE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pend_q  <= 1'b0;
      inflight_q <= 1'b0;
      swap_q     <= 1'b0;
      data_i_q   <= '0;
      addr_w_q   <= '0;
    end else if (flush) begin
      wr_pend_q  <= 1'b0;
      inflight_q <= 1'b0;
      swap_q     <= 1'b0;
      data_i_q   <= '0;
      addr_w_q   <= '0;
    end else begin
      wr_pend_q  <= accept;
      inflight_q <= rd_issue;
      swap_q     <= swap;
      if (accept) begin
        data_i_q <= in_data;
        addr_w_q <= {~rb_q, wr_off_q};
      end
    end
  end

  dmem_skid_fifo #(.BITS(BITS)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (flush),
    .push      (inflight_q),
    .push_data (data_o),
    .pop       (pop),
    .head      (fifo_head),
    .cnt       (fifo_cnt)
  );

  assign out_valid = (fifo_cnt != 2'd0);
  assign out_data  = fifo_head;
  assign cen       = ~(rd_issue | wr_pend_q);
  assign gwen      = 1'b1;
  assign addr_r    = {rb_q, rd_off_q};
  assign addr_w    = addr_w_q;
  assign data_i    = data_i_q;
  assign bank_o    = rb_q;
  assign swap_o    = swap_q;

endmodule
